// File: rtl/axi4s_downsizer.sv
// AXI4-Stream width downsizer: splits each wide beat into OUT_WIDTH sub-words, LSB first,
// dropping trailing all-zero-keep sub-words and moving tlast onto the last emitted one.
module axi4s_downsizer #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_WIDTH-1:0]    i_data_tdata_i,
  input  logic [IN_WIDTH/8-1:0]  i_data_tkeep_i,
  input  logic                   i_data_tlast_i,
  input  logic                   i_data_tvalid_i,
  output logic                   i_data_tready_o,
  output logic [OUT_WIDTH-1:0]   o_data_tdata_o,
  output logic [OUT_WIDTH/8-1:0] o_data_tkeep_o,
  output logic                   o_data_tlast_o,
  output logic                   o_data_tvalid_o,
  input  logic                   o_data_tready_i
);

  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W  = $clog2(RATIO);
  localparam int IN_KW  = IN_WIDTH / 8;
  localparam int OUT_KW = OUT_WIDTH / 8;

  logic [IN_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [IN_KW-1:0]    buf_keep_q, buf_keep_d;
  logic                buf_last_q, buf_last_d;
  logic                full_q, full_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic is_final;
  logic in_acc;
  logic out_acc;

  // Current sub-word is final when no keep bit survives in any higher sub-word.
  always_comb begin
    is_final = 1'b1;
    for (int k = 0; k < RATIO; k++) begin
      if ((k > int'(idx_q)) && (|buf_keep_q[k*OUT_KW +: OUT_KW])) begin
        is_final = 1'b0;
      end
    end
  end

  assign o_data_tvalid_o = full_q;
  assign o_data_tdata_o  = buf_data_q[idx_q*OUT_WIDTH +: OUT_WIDTH];
  assign o_data_tkeep_o  = buf_keep_q[idx_q*OUT_KW +: OUT_KW];
  assign o_data_tlast_o  = buf_last_q & is_final;

  assign out_acc         = full_q & o_data_tready_i;
  assign i_data_tready_o = ~rst & (~full_q | (out_acc & is_final));
  assign in_acc          = i_data_tvalid_i & i_data_tready_o;

  always_comb begin
    buf_data_d = buf_data_q;
    buf_keep_d = buf_keep_q;
    buf_last_d = buf_last_q;
    full_d     = full_q;
    idx_d      = idx_q;
    if (in_acc) begin
      buf_data_d = i_data_tdata_i;
      buf_keep_d = i_data_tkeep_i;
      buf_last_d = i_data_tlast_i;
      full_d     = 1'b1;
      idx_d      = '0;
    end else if (out_acc) begin
      if (is_final) begin
        full_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data_q <= '0;
      buf_keep_q <= '0;
      buf_last_q <= 1'b0;
      full_q     <= 1'b0;
      idx_q      <= '0;
    end else begin
      buf_data_q <= buf_data_d;
      buf_keep_q <= buf_keep_d;
      buf_last_q <= buf_last_d;
      full_q     <= full_d;
      idx_q      <= idx_d;
    end
  end

endmodule

// File: doc/axi4s_downsizer.md
# axi4s_downsizer

Narrows an AXI4-Stream from `IN_WIDTH` to `OUT_WIDTH` bits. Each wide input beat is split into sub-words emitted least-significant first. Sub-words above the highest non-zero `tkeep` lane are dropped, and `tlast` moves to the final emitted sub-word. It sits on the read side of the wide stream FIFOs and feeds narrow consumers such as the byte-oriented compression stages.

## Interface

**Parameters**
- `IN_WIDTH`, default 512: input `tdata` width in bits. Must be a multiple of `OUT_WIDTH`.
- `OUT_WIDTH`, default 64: output `tdata` width in bits. Must be a multiple of 8.
- Derived: `RATIO = IN_WIDTH/OUT_WIDTH`. Must be a power of 2 and ≥ 2.
- Derived: `IDX_W = $clog2(RATIO)`.

**Ports**
- `clk`, input, 1: single clock; all logic is in this domain.
- `rst`, input, 1: asynchronous, active-high reset.
- `i_data`, `AXI4S.s`, `IN_WIDTH`: wide input stream. Uses `tdata`, `tkeep` (`IN_WIDTH/8`), `tlast`, `tvalid`, `tready`.
- `o_data`, `AXI4S.m`, `OUT_WIDTH`: narrow output stream. Uses the same signal set with `OUT_WIDTH`.

## Operation

**State**
- One-beat holding register: `buf_data`, `buf_keep`, `buf_last`.
- `full` flag.
- Sub-word index `idx`, `IDX_W` bits.

**Sub-word k**
- Data: `buf_data[k*OUT_WIDTH +: OUT_WIDTH]`.
- Keep: `buf_keep[k*OUT_WIDTH/8 +: OUT_WIDTH/8]`.

**is_final**
- True when every keep bit belonging to sub-words above `idx` is zero.
- Combinational, computed from `buf_keep` and `idx`.

**Outputs**
- `o_data.tvalid = full`.
- `o_data.tdata` / `o_data.tkeep` = sub-word `idx`.
- `o_data.tlast = buf_last & is_final`.

**Input ready**
- `i_data.tready = !rst & (!full | (o_data.tvalid & o_data.tready & is_final))`.
- This gives a zero-bubble reload.

**Input accept** (`i_data.tvalid & i_data.tready`)
- Load the holding register.
- Set `full = 1` and `idx = 0`.

**Output accept, not final**
- `idx <= idx + 1`.
- Buffer unchanged.

**Output accept, final**
- If an input accept happens in the same cycle, reload per the input-accept rule.
- Otherwise set `full = 0` and `idx = 0`.

**Emission rules**
- Interior sub-words whose keep is all-zero are still emitted, with `tkeep = 0`.
- Only trailing all-zero sub-words are skipped.

**All-zero `tkeep` input beat**
- `is_final` is true at `idx = 0`.
- Exactly one sub-word is emitted: `tkeep = 0`, `tlast = buf_last`.
- This preserves packet boundaries.

**Backpressure**
- While `o_data.tvalid & !o_data.tready`, all `o_data` fields hold stable.
- `idx` does not advance.

**No packet state**
- The block holds no packet-level state.
- `tlast` is carried through per beat only.

**Reset**
- Asserting `rst` at any time, including mid-beat, immediately clears `full`, `idx`, `buf_data`, `buf_keep` and `buf_last` to 0.
- The remaining sub-words of the held beat are discarded.

## Timing

**Reset values**
- `o_data.tvalid = 0`, `o_data.tdata = 0`, `o_data.tkeep = 0`, `o_data.tlast = 0`.
- `i_data.tready = 0` while `rst` is high; 1 in the first cycle after release.

**Latency**
- A beat accepted on edge N is presented as sub-word 0 from edge N onward, i.e. visible in cycle N+1.

**Throughput**
- Emitting n sub-words takes n cycles.
- With `o_data.tready` held at 1 and input always valid, output is continuous with no idle cycles between beats.

**Handshakes**
- `o_data.tready` → `i_data.tready` is a combinational path.
- No other combinational input-to-output path exists.
- `o_data.tvalid` never deasserts without a handshake, except on reset.

## Test plan

All scenarios use `IN_WIDTH=64`, `OUT_WIDTH=16` (`RATIO=4`).

1. **Reset.** Hold `rst` for 3 cycles with `i_data.tvalid=1` → `o_data.tvalid=0`, `i_data.tready=0` throughout. After release, `i_data.tready=1` and the first beat is accepted.
2. **Full beat, no backpressure.** Input `tdata=0x4444_3333_2222_1111`, `tkeep=0xFF`, `tlast=1`, with `o_data.tready=1` → outputs 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles, each with `tkeep=0x3`. `tlast=1` only on 0x4444. A second queued beat is accepted in the same cycle as 0x4444 and its first sub-word follows with no gap.
3. **Partial keep.** Input `tkeep=0x07`, `tlast=1` → 2 sub-words: 0x1111 with `keep 0x3`, `last 0`; then 0x2222 with `keep 0x1`, `last 1`. Interior-gap case: `tkeep=0xC3` → 4 sub-words with keep 0x3, 0x0, 0x0, 0x3.
4. **Empty beat.** Input `tkeep=0x00`, `tlast=1` → exactly 1 output beat with `tkeep=0`, `tlast=1`.
5. **Random backpressure.** Drive `o_data.tready` randomly over 1000 random beats → the output sequence matches the scoreboard model, and `tdata`/`tkeep`/`tlast` stay stable during every stalled cycle.
6. **Reset mid-beat.** Pulse `rst` asynchronously after the second sub-word is accepted → `o_data.tvalid` drops in the same cycle. After release, no remaining sub-word of that beat is ever emitted.
